imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time instruction-memory writer for the single-cycle MIPS core. It accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit words. Each word is written into the instruction memory that the fetch unit reads. The core is held in reset until the image is complete, and the block then releases it.

## Interface
Parameters:
- ADDR_W, 10, instruction-memory word-address width; capacity 2^ADDR_W words.

Ports:
- Clk  input  1  core clock; all state changes on rising edge.
- Reset  input  1  synchronous, active-high; one clock, synchronous reset, active-high, fixed.
- start  input  1  one-cycle pulse; restarts a load from DONE or ERR, ignored elsewhere.
- in_valid  input  1  in_data holds a byte.
- in_data  input  8  stream byte.
- in_ready  output  1  loader can accept a byte this cycle.
- im_we  output  1  instruction-memory write strobe, one cycle per word.
- im_addr  output  ADDR_W  word address for im_we.
- im_wdata  output  32  word for im_we.
- cpu_hold  output  1  drives the fetch unit's reset (ifu_Reset); 1 = core held.
- done  output  1  image loaded successfully; level.
- err  output  1  load failed; level.

## Operation
- Stream format:
  - LEN_HI byte, then LEN_LO byte, giving N, a 16-bit word count.
  - Then 4N payload bytes, MSB first per word.
  - Then, when configured, one checksum byte.
- A byte is accepted when in_valid && in_ready at a rising edge. Neither side may assume acceptance otherwise. in_data is don't-care while in_valid=0.
- States and transitions:
  - S_LEN_HI: accept a byte → S_LEN_LO.
  - S_LEN_LO: accept a byte to form N.
    - If N > 2^ADDR_W → S_ERR.
    - Else if N=0 → S_SUM, or S_DONE without the macro.
    - Else → S_DATA.
  - S_DATA: a 2-bit byte counter shifts bytes into a 32-bit assembly register.
    - The 4th byte issues a write and increments the word counter.
    - After the word-N write → S_SUM, or S_FLUSH without the macro.
  - S_FLUSH: one cycle → S_DONE. Only reached without the macro.
  - S_SUM: accept a byte.
    - Equal to the running XOR → S_DONE.
    - Else → S_ERR.
  - S_DONE / S_ERR: in_ready=0. start → S_LEN_HI, with counters, XOR and assembly register cleared.
- in_ready=1 in S_LEN_HI, S_LEN_LO, S_DATA and S_SUM; 0 otherwise.
- Writes:
  - im_addr = word index, starting at 0 and incrementing by 1.
  - im_wdata = {b0,b1,b2,b3}, where b0 is the first accepted byte of the word.
  - Counter width is ADDR_W+1, so N=2^ADDR_W is legal. The final im_addr = 2^ADDR_W−1, and im_addr never wraps.
- cpu_hold=1 in every state except S_DONE. On error the core stays held.
- Reset mid-load: the partial image is abandoned and the state returns to S_LEN_HI. Already-written words are not cleared.

## Timing
- Reset values: state S_LEN_HI, in_ready=1, im_we=0, im_addr=0, im_wdata=0, cpu_hold=1, done=0, err=0.
- im_we, im_addr and im_wdata are registered.
  - If the 4th byte of a word is accepted at edge k, im_we=1 during cycle k+1 only.
  - Back-to-back bytes give at most one write per 4 cycles.
- Without the macro:
  - The last payload byte is accepted at edge k.
  - The final im_we is high in cycle k+1 (S_FLUSH).
  - done=1 and cpu_hold=0 from edge k+2.
- With the macro:
  - The checksum byte is accepted at edge m, which is ≥ the final-write cycle.
  - done or err is asserted from edge m+1.
- err is asserted one edge after the offending LEN_LO or checksum byte is accepted.
- start pulse at edge s: done/err=0, cpu_hold=1 and in_ready=1 from edge s+1.
- Reset has priority over start and over byte acceptance in the same cycle.
- Stalls: gaps in in_valid may occur at any byte position and change nothing but latency.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - S_SUM exists.
  - The running XOR covers LEN_HI, LEN_LO and all payload bytes.
  - A mismatching trailer byte → err=1.
- Undefined:
  - No trailer byte; S_SUM is never entered.
  - err is raised only on length overflow.
  - A byte offered after the payload sees in_ready=0.

## Test plan
- Without the macro, stream 00 02 12 34 56 78 9A BC DE F0 with no gaps:
  - im_we at addr 0 with data 0x12345678, then at addr 1 with data 0x9ABCDEF0.
  - done=1 and cpu_hold=0 two cycles after the last byte.
- With the macro, stream 00 01 DE AD BE EF then trailer 0x23 (0x00^0x01^0xDE^0xAD^0xBE^0xEF):
  - One write of 0xDEADBEEF at addr 0.
  - done=1 one cycle after the trailer.
- Same stream as the previous scenario with trailer 0x24:
  - err=1, done=0, cpu_hold stays 1.
  - A start pulse then returns in_ready=1 with err=0.
- ADDR_W=2, length bytes 00 05:
  - err=1 next cycle, no im_we ever.
  - With length 00 04 followed by 16 bytes: last write at addr 3 and done asserted.
- Random in_valid gaps during the first scenario's stream:
  - Identical write addresses and data to the gap-free run.
- Reset asserted after 6 payload bytes, then the first scenario's full stream replayed:
  - Writes restart at addr 0 with correct words and done asserted.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: boot loader that assembles a big-endian byte stream into 32-bit instruction-memory words and holds the core until done.
// Latency: im_we one cycle after a word's 4th byte; done/err visible the cycle after the final state transition (FLUSH or checksum).
// Backpressure: in_ready low in FLUSH/DONE/ERR; optional trailer checksum enabled by LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_FLUSH,
        S_SUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam int CW = ADDR_W + 1;
    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

    state_t          state_q;
    state_t          state_d;
    logic [7:0]      len_hi_q;
    logic [15:0]     n_q;
    logic [1:0]      byte_cnt_q;
    logic [23:0]     asm_q;
    logic [CW-1:0]   word_cnt_q;
    logic [15:0]     n_in;
    logic            last_word;
    logic            accept;
    logic            restart;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]      xor_q;
`endif

    assign accept    = in_valid && in_ready;
    assign restart   = start && (state_q == S_DONE || state_q == S_ERR);
    assign n_in      = {len_hi_q, in_data};
    // Word counter is one bit wider than the address so N = 2^ADDR_W terminates cleanly.
    assign last_word = (17'(word_cnt_q) + 17'd1) == {1'b0, n_q};

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_LEN_HI;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        cpu_hold = 1'b1;
        done     = 1'b0;
        err      = 1'b0;
        case (state_q)
            S_LEN_HI: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if ({1'b0, n_in} > MAX_WORDS) begin
                        state_d = S_ERR;
                    end else if (n_in == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = S_SUM;
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                in_ready = 1'b1;
                if (in_valid && byte_cnt_q == 2'd3 && last_word) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = S_SUM;
`else
                    state_d = S_FLUSH;
`endif
                end
            end
            S_FLUSH: begin
                state_d = S_DONE;
            end
`ifdef LOADER_CHECKSUM_EN
            S_SUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = (in_data == xor_q) ? S_DONE : S_ERR;
                end
            end
`endif
            S_DONE: begin
                cpu_hold = 1'b0;
                done     = 1'b1;
                if (start) begin
                    state_d = S_LEN_HI;
                end
            end
            S_ERR: begin
                err = 1'b1;
                if (start) begin
                    state_d = S_LEN_HI;
                end
            end
            default: begin
                state_d = S_LEN_HI;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            len_hi_q   <= 8'd0;
            n_q        <= 16'd0;
            byte_cnt_q <= 2'd0;
            asm_q      <= 24'd0;
            word_cnt_q <= '0;
            im_we      <= 1'b0;
            im_addr    <= '0;
            im_wdata   <= 32'd0;
        end else begin
            im_we <= 1'b0;
            if (restart) begin
                byte_cnt_q <= 2'd0;
                asm_q      <= 24'd0;
                word_cnt_q <= '0;
            end
            if (accept) begin
                case (state_q)
                    S_LEN_HI: len_hi_q <= in_data;
                    S_LEN_LO: n_q <= n_in;
                    S_DATA: begin
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            im_we      <= 1'b1;
                            im_addr    <= word_cnt_q[ADDR_W-1:0];
                            im_wdata   <= {asm_q, in_data};
                            word_cnt_q <= word_cnt_q + CW'(1);
                        end else begin
                            // Older bytes shift toward the MSB, so the first byte lands in [31:24].
                            asm_q <= {asm_q[15:0], in_data};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Running XOR over length and payload bytes; the trailer itself is compared, not folded in.
    always_ff @(posedge Clk) begin
        if (Reset || restart) begin
            xor_q <= 8'd0;
        end else if (accept && (state_q == S_LEN_HI || state_q == S_LEN_LO || state_q == S_DATA)) begin
            xor_q <= xor_q ^ in_data;
        end
    end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboarded bench for imem_loader: a wide instance (ADDR_W=10) and a tiny one (ADDR_W=2) for capacity limits.
module tb_imem_loader;
    localparam int AW_A = 10;
    localparam int AW_B = 2;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] data;
    } wr_t;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic            rst_a, start_a, vld_a, rdy_a, we_a, hold_a, done_a, err_a;
    logic [7:0]      dat_a;
    logic [AW_A-1:0] addr_a;
    logic [31:0]     wdata_a;
    logic            rst_b, start_b, vld_b, rdy_b, we_b, hold_b, done_b, err_b;
    logic [7:0]      dat_b;
    logic [AW_B-1:0] addr_b;
    logic [31:0]     wdata_b;

    imem_loader #(.ADDR_W(AW_A)) dut_a (
        .Clk(Clk), .Reset(rst_a), .start(start_a), .in_valid(vld_a), .in_data(dat_a),
        .in_ready(rdy_a), .im_we(we_a), .im_addr(addr_a), .im_wdata(wdata_a),
        .cpu_hold(hold_a), .done(done_a), .err(err_a)
    );

    imem_loader #(.ADDR_W(AW_B)) dut_b (
        .Clk(Clk), .Reset(rst_b), .start(start_b), .in_valid(vld_b), .in_data(dat_b),
        .in_ready(rdy_b), .im_we(we_b), .im_addr(addr_b), .im_wdata(wdata_b),
        .cpu_hold(hold_b), .done(done_b), .err(err_b)
    );

    wr_t        exp_a[$];
    wr_t        exp_b[$];
    wr_t        e_a, e_b;
    logic [7:0] stream[$];
    int         checks = 0;
    int         errors = 0;
    bit         gaps = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every write strobe must match the next expected write in order.
    always @(negedge Clk) begin
        if (we_a === 1'b1) begin
            if (exp_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL write_a_unexpected actual addr=%h data=%h required none", addr_a, wdata_a);
            end else begin
                e_a = exp_a.pop_front();
                chk("write_a_addr", 32'(addr_a), 32'(e_a.addr));
                chk("write_a_data", wdata_a, e_a.data);
            end
        end
        if (we_b === 1'b1) begin
            if (exp_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL write_b_unexpected actual addr=%h data=%h required none", addr_b, wdata_b);
            end else begin
                e_b = exp_b.pop_front();
                chk("write_b_addr", 32'(addr_b), 32'(e_b.addr));
                chk("write_b_data", wdata_b, e_b.data);
            end
        end
    end

    task automatic push_exp(input bit sel, input logic [15:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        if (sel) exp_b.push_back(w);
        else exp_a.push_back(w);
    endtask

    // Starts and ends at a falling edge; holds the byte until an edge sees in_ready high.
    task automatic send(input bit sel, input logic [7:0] b);
        int   waited;
        logic r;
        waited = 0;
        if (gaps) repeat ($urandom_range(0, 3)) @(negedge Clk);
        if (sel) begin vld_b = 1'b1; dat_b = b; end
        else begin vld_a = 1'b1; dat_a = b; end
        forever begin
            r = sel ? rdy_b : rdy_a;
            @(posedge Clk);
            if (r === 1'b1) break;
            waited++;
            if (waited > 20) begin
                checks++;
                errors++;
                $display("FAIL send_timeout actual=no_ready required=ready byte=%h", b);
                break;
            end
            @(negedge Clk);
        end
        @(negedge Clk);
        if (sel) vld_b = 1'b0;
        else vld_a = 1'b0;
    endtask

    task automatic send_stream(input bit sel, input bit add_sum, input logic [7:0] flip);
        logic [7:0] x;
        x = 8'h00;
        foreach (stream[i]) begin
            send(sel, stream[i]);
            x = x ^ stream[i];
        end
        if (add_sum) send(sel, x ^ flip);
    endtask

    task automatic pulse_start(input bit sel);
        if (sel) start_b = 1'b1;
        else start_a = 1'b1;
        @(negedge Clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic expect_done(input bit sel, input string name);
        int n;
        n = 0;
        while (((sel ? done_b : done_a) !== 1'b1) && n < 8) begin
            @(negedge Clk);
            n++;
        end
        chk(name, 32'(sel ? done_b : done_a), 32'd1);
        chk({name, "_hold"}, 32'(sel ? hold_b : hold_a), 32'd0);
        chk({name, "_err"}, 32'(sel ? err_b : err_a), 32'd0);
    endtask

    task automatic drained(input bit sel, input string name);
        #1;
        chk(name, 32'(sel ? exp_b.size() : exp_a.size()), 32'd0);
        @(negedge Clk);
    endtask

    task automatic fill_s1();
        stream = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        push_exp(1'b0, 16'd0, 32'h12345678);
        push_exp(1'b0, 16'd1, 32'h9ABCDEF0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_a = 1'b1; start_a = 1'b0; vld_a = 1'b0; dat_a = 8'h00;
        rst_b = 1'b1; start_b = 1'b0; vld_b = 1'b0; dat_b = 8'h00;
        @(negedge Clk);
        @(negedge Clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
        chk("rst_in_ready", 32'(rdy_a), 32'd1);
        chk("rst_im_we", 32'(we_a), 32'd0);
        chk("rst_im_addr", 32'(addr_a), 32'd0);
        chk("rst_im_wdata", wdata_a, 32'd0);
        chk("rst_cpu_hold", 32'(hold_a), 32'd1);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_err", 32'(err_a), 32'd0);

        // Two-word image without gaps; exact completion timing.
        fill_s1();
        send_stream(1'b0, CK, 8'h00);
`ifdef LOADER_CHECKSUM_EN
        chk("s1_done", 32'(done_a), 32'd1);
        chk("s1_hold", 32'(hold_a), 32'd0);
`else
        chk("s1_flush_we", 32'(we_a), 32'd1);
        chk("s1_flush_ready", 32'(rdy_a), 32'd0);
        chk("s1_flush_done", 32'(done_a), 32'd0);
        chk("s1_flush_hold", 32'(hold_a), 32'd1);
        @(negedge Clk);
        chk("s1_done", 32'(done_a), 32'd1);
        chk("s1_hold", 32'(hold_a), 32'd0);
`endif
        drained(1'b0, "s1_drained");
        chk("s1_done_ready", 32'(rdy_a), 32'd0);

        // Restart, then the same image with random valid gaps.
        pulse_start(1'b0);
        chk("start_ready", 32'(rdy_a), 32'd1);
        chk("start_done", 32'(done_a), 32'd0);
        chk("start_hold", 32'(hold_a), 32'd1);
        gaps = 1'b1;
        fill_s1();
        send_stream(1'b0, CK, 8'h00);
        gaps = 1'b0;
        expect_done(1'b0, "gap_done");
        drained(1'b0, "gap_drained");

        // Reset after 6 payload bytes; a byte offered during reset must be ignored.
        pulse_start(1'b0);
        push_exp(1'b0, 16'd0, 32'h12345678);
        stream = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
        send_stream(1'b0, 1'b0, 8'h00);
        rst_a = 1'b1;
        vld_a = 1'b1;
        dat_a = 8'hFF;
        @(negedge Clk);
        rst_a = 1'b0;
        vld_a = 1'b0;
        chk("midrst_ready", 32'(rdy_a), 32'd1);
        chk("midrst_hold", 32'(hold_a), 32'd1);
        chk("midrst_done", 32'(done_a), 32'd0);
        fill_s1();
        send_stream(1'b0, CK, 8'h00);
        expect_done(1'b0, "midrst_replay_done");
        drained(1'b0, "midrst_drained");

`ifdef LOADER_CHECKSUM_EN
        // Trailer 0x23 = 00^01^DE^AD^BE^EF is good; 0x24 is bad.
        pulse_start(1'b0);
        stream = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        push_exp(1'b0, 16'd0, 32'hDEADBEEF);
        send_stream(1'b0, 1'b0, 8'h00);
        send(1'b0, 8'h23);
        chk("sum_ok_done", 32'(done_a), 32'd1);
        chk("sum_ok_err", 32'(err_a), 32'd0);
        drained(1'b0, "sum_ok_drained");
        pulse_start(1'b0);
        push_exp(1'b0, 16'd0, 32'hDEADBEEF);
        send_stream(1'b0, 1'b0, 8'h00);
        send(1'b0, 8'h24);
        chk("sum_bad_err", 32'(err_a), 32'd1);
        chk("sum_bad_done", 32'(done_a), 32'd0);
        chk("sum_bad_hold", 32'(hold_a), 32'd1);
        chk("sum_bad_ready", 32'(rdy_a), 32'd0);
        pulse_start(1'b0);
        chk("sum_restart_ready", 32'(rdy_a), 32'd1);
        chk("sum_restart_err", 32'(err_a), 32'd0);
        drained(1'b0, "sum_bad_drained");
`endif

        // Capacity 4 words: N=5 overflows, N=4 fills addr 0..3.
        send(1'b1, 8'h00);
        send(1'b1, 8'h05);
        chk("ovf_err", 32'(err_b), 32'd1);
        chk("ovf_done", 32'(done_b), 32'd0);
        chk("ovf_hold", 32'(hold_b), 32'd1);
        chk("ovf_ready", 32'(rdy_b), 32'd0);
        repeat (3) @(negedge Clk);
        chk("ovf_err_level", 32'(err_b), 32'd1);
        pulse_start(1'b1);
        chk("ovf_restart_ready", 32'(rdy_b), 32'd1);
        chk("ovf_restart_err", 32'(err_b), 32'd0);
        stream = '{8'h00, 8'h04};
        for (int j = 0; j < 16; j++) stream.push_back(8'(j * 17));
        push_exp(1'b1, 16'd0, 32'h00112233);
        push_exp(1'b1, 16'd1, 32'h44556677);
        push_exp(1'b1, 16'd2, 32'h8899AABB);
        push_exp(1'b1, 16'd3, 32'hCCDDEEFF);
        send_stream(1'b1, CK, 8'h00);
        expect_done(1'b1, "full_done");
        drained(1'b1, "full_drained");
        chk("full_last_addr", 32'(addr_b), 32'd3);

        // Empty image completes without any write.
        pulse_start(1'b1);
        stream = '{8'h00, 8'h00};
        send_stream(1'b1, CK, 8'h00);
        expect_done(1'b1, "empty_done");
        drained(1'b1, "empty_drained");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
